// File: rtl/cache_req_checker_if.sv
// rtl/cache_req_checker_if.sv - snooped core<->cache request/completion bundle
// master: the side that drives the request and completion strobes.
// slave : the passive checker, which only observes them.
interface cache_req_checker_if;
  logic [26:0] core2cache_rd_addr;
  logic [26:0] core2cache_wr_addr;
  logic [31:0] core2cache_wr_data;
  logic        core2cache_rd_en;
  logic        core2cache_wr_en;
  logic        cache2core_rd_fin;
  logic        cache2core_wr_fin;
  logic [31:0] cache2core_rd_data;

  modport master (
    output core2cache_rd_addr, core2cache_wr_addr, core2cache_wr_data,
    output core2cache_rd_en, core2cache_wr_en,
    output cache2core_rd_fin, cache2core_wr_fin, cache2core_rd_data
  );

  modport slave (
    input core2cache_rd_addr, core2cache_wr_addr, core2cache_wr_data,
    input core2cache_rd_en, core2cache_wr_en,
    input cache2core_rd_fin, cache2core_wr_fin, cache2core_rd_data
  );
endinterface

// File: rtl/cache_req_checker.sv
// rtl/cache_req_checker.sv - passive scoreboard for the core<->cache request path
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   bus (slave)        snooped request strobes and completions
//   pass/fail/unknown_count, max_latency   saturating statistics
//   busy, proto_err, timeout_flag          status and sticky error flags
//   last_fail_addr/exp/got                 most recent mismatch capture
// Optional feature: CHECKER_LAST_FAIL_EN builds the last-fail capture
// registers; without it those outputs are tied to 0.
module cache_req_checker #(
  parameter int ENTRIES = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  cache_req_checker_if.slave  bus,
  output logic [15:0]         pass_count,
  output logic [15:0]         fail_count,
  output logic [15:0]         unknown_count,
  output logic [15:0]         max_latency,
  output logic                busy,
  output logic                proto_err,
  output logic                timeout_flag,
  output logic [26:0]         last_fail_addr,
  output logic [31:0]         last_fail_exp,
  output logic [31:0]         last_fail_got
);

  localparam int IW = $clog2(ENTRIES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_WAIT = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;

  logic [1:0]         state;
  logic [26:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               rd_hit_q;
  logic [31:0]        rd_exp_q;
  logic [31:0]        lat;
  logic [31:0]        lat_k;
  logic [IW-1:0]      alloc_ptr;
  logic [ENTRIES-1:0] vld;
  logic [26:0]        tag [ENTRIES];
  logic [31:0]        dat [ENTRIES];

  logic          rd_hit;
  logic [31:0]   rd_exp;
  logic          wr_hit;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] commit_idx;

  logic is_idle, any_en, any_fin;
  logic accept_wr, accept_rd;
  logic wr_commit, rd_done, fin_match, fail_evt, violation;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Read lookup runs against the live request address so the hit/expected
  // data can be latched at acceptance; write lookup uses the captured address.
  always_comb begin
    rd_hit = 1'b0;
    rd_exp = '0;
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (vld[i] && tag[i] == bus.core2cache_rd_addr) begin
        rd_hit = 1'b1;
        rd_exp = dat[i];
      end
      if (vld[i] && tag[i] == addr_q) begin
        wr_hit = 1'b1;
        wr_idx = IW'(i);
      end
    end
  end

  assign commit_idx = wr_hit ? wr_idx : alloc_ptr;

  assign is_idle   = (state == IDLE);
  assign any_en    = bus.core2cache_rd_en | bus.core2cache_wr_en;
  assign any_fin   = bus.cache2core_rd_fin | bus.cache2core_wr_fin;
  assign accept_wr = is_idle & bus.core2cache_wr_en & ~bus.core2cache_rd_en;
  assign accept_rd = is_idle & bus.core2cache_rd_en & ~bus.core2cache_wr_en;
  assign wr_commit = (state == WR_WAIT) & bus.cache2core_wr_fin;
  assign rd_done   = (state == RD_WAIT) & bus.cache2core_rd_fin;
  assign fin_match = wr_commit | rd_done;
  assign fail_evt  = rd_done & rd_hit_q & (bus.cache2core_rd_data != rd_exp_q);

  // lat counts completed wait cycles; lat_k is the latency a fin sampled
  // this cycle would have (1 for a fin on the cycle right after the en).
  assign lat_k = lat + 32'd1;

  assign violation =
      (is_idle & bus.core2cache_rd_en & bus.core2cache_wr_en) |
      (~is_idle & any_en) |
      (is_idle & any_fin) |
      ((state == WR_WAIT) & bus.cache2core_rd_fin) |
      ((state == RD_WAIT) & bus.cache2core_wr_fin);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rd_hit_q      <= 1'b0;
      rd_exp_q      <= '0;
      lat           <= '0;
      alloc_ptr     <= '0;
      vld           <= '0;
      pass_count    <= '0;
      fail_count    <= '0;
      unknown_count <= '0;
      max_latency   <= '0;
      proto_err     <= 1'b0;
      timeout_flag  <= 1'b0;
    end else begin
      if (violation) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (accept_wr) begin
            state   <= WR_WAIT;
            busy    <= 1'b1;
            addr_q  <= bus.core2cache_wr_addr;
            wdata_q <= bus.core2cache_wr_data;
            lat     <= '0;
          end else if (accept_rd) begin
            state    <= RD_WAIT;
            busy     <= 1'b1;
            addr_q   <= bus.core2cache_rd_addr;
            rd_hit_q <= rd_hit;
            rd_exp_q <= rd_exp;
            lat      <= '0;
          end
        end
        WR_WAIT, RD_WAIT: begin
          if (fin_match) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (lat_k > {16'h0, max_latency})
              max_latency <= (lat_k > 32'h0000_FFFF) ? 16'hFFFF : lat_k[15:0];
            if (wr_commit) begin
              vld[commit_idx] <= 1'b1;
              if (!wr_hit) alloc_ptr <= alloc_ptr + IW'(1);
            end else if (!rd_hit_q) begin
              unknown_count <= sat_inc(unknown_count);
            end else if (fail_evt) begin
              fail_count <= sat_inc(fail_count);
            end else begin
              pass_count <= sat_inc(pass_count);
            end
          end else if (lat_k >= 32'(TIMEOUT)) begin
            // Drop the request silently apart from the sticky flag.
            state        <= IDLE;
            busy         <= 1'b0;
            timeout_flag <= 1'b1;
          end else begin
            lat <= lat_k;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Table payload carries no reset; only the valid bits need clearing.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      tag[commit_idx] <= addr_q;
      dat[commit_idx] <= wdata_q;
    end
  end

`ifdef CHECKER_LAST_FAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_fail_addr <= '0;
      last_fail_exp  <= '0;
      last_fail_got  <= '0;
    end else if (fail_evt) begin
      last_fail_addr <= addr_q;
      last_fail_exp  <= rd_exp_q;
      last_fail_got  <= bus.cache2core_rd_data;
    end
  end
`else
  assign last_fail_addr = '0;
  assign last_fail_exp  = '0;
  assign last_fail_got  = '0;
`endif

endmodule

// File: tb/tb_cache_req_checker.sv
// tb/tb_cache_req_checker.sv - self-checking bench for cache_req_checker
module tb_cache_req_checker;
  localparam int ENTRIES = 16;
  localparam int TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_req_checker_if bus();

  logic [15:0] pass_count, fail_count, unknown_count, max_latency;
  logic        busy, proto_err, timeout_flag;
  logic [26:0] last_fail_addr;
  logic [31:0] last_fail_exp, last_fail_got;

  cache_req_checker #(.ENTRIES(ENTRIES), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .pass_count     (pass_count),
    .fail_count     (fail_count),
    .unknown_count  (unknown_count),
    .max_latency    (max_latency),
    .busy           (busy),
    .proto_err      (proto_err),
    .timeout_flag   (timeout_flag),
    .last_fail_addr (last_fail_addr),
    .last_fail_exp  (last_fail_exp),
    .last_fail_got  (last_fail_got)
  );

  localparam int K_WR   = 0;
  localparam int K_PASS = 1;
  localparam int K_FAIL = 2;
  localparam int K_UNK  = 3;

  typedef struct {
    int          kind;
    logic [26:0] addr;
    logic [31:0] data;      // write data, or data returned on rd_fin
    int          k;         // cycles from en to fin
    logic [31:0] exp_data;  // shadow data a failing read is compared against
  } vec_t;

  typedef struct {
    logic [15:0] pass_c;
    logic [15:0] fail_c;
    logic [15:0] unk_c;
    logic [15:0] maxlat;
    logic [26:0] lf_addr;
    logic [31:0] lf_exp;
    logic [31:0] lf_got;
  } snap_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  snap_t exp_s;
  snap_t sb[$];
  vec_t  vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    exp_s = '{default: '0};
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_exp();
  endtask

  task automatic check_snap(input string tag, input snap_t e);
    check({tag, ".pass"},    32'(pass_count),     32'(e.pass_c));
    check({tag, ".fail"},    32'(fail_count),     32'(e.fail_c));
    check({tag, ".unknown"}, 32'(unknown_count),  32'(e.unk_c));
    check({tag, ".max_lat"}, 32'(max_latency),    32'(e.maxlat));
    check({tag, ".lf_addr"}, 32'(last_fail_addr), 32'(e.lf_addr));
    check({tag, ".lf_exp"},  last_fail_exp,       e.lf_exp);
    check({tag, ".lf_got"},  last_fail_got,       e.lf_got);
    check({tag, ".busy"},    32'(busy),           32'd0);
  endtask

  task automatic check_all_zero(input string tag, input logic pe);
    check({tag, ".pass"},    32'(pass_count),     32'd0);
    check({tag, ".fail"},    32'(fail_count),     32'd0);
    check({tag, ".unknown"}, 32'(unknown_count),  32'd0);
    check({tag, ".max_lat"}, 32'(max_latency),    32'd0);
    check({tag, ".busy"},    32'(busy),           32'd0);
    check({tag, ".proto"},   32'(proto_err),      32'(pe));
    check({tag, ".timeout"}, 32'(timeout_flag),   32'd0);
    check({tag, ".lf_addr"}, 32'(last_fail_addr), 32'd0);
    check({tag, ".lf_exp"},  last_fail_exp,       32'd0);
    check({tag, ".lf_got"},  last_fail_got,       32'd0);
  endtask

  task automatic note_latency(input int k);
    if (k > int'(exp_s.maxlat)) exp_s.maxlat = 16'(k);
  endtask

  task automatic do_write(input logic [26:0] addr, input logic [31:0] data, input int k);
    bus.core2cache_wr_en   = 1'b1;
    bus.core2cache_wr_addr = addr;
    bus.core2cache_wr_data = data;
    tick();
    bus.core2cache_wr_en = 1'b0;
    check("wr.busy_during", 32'(busy), 32'd1);
    repeat (k - 1) tick();
    bus.cache2core_wr_fin = 1'b1;
    tick();
    bus.cache2core_wr_fin = 1'b0;
    note_latency(k);
    check("wr.busy_after", 32'(busy), 32'd0);
    check("wr.max_lat", 32'(max_latency), 32'(exp_s.maxlat));
  endtask

  task automatic do_read(input logic [26:0] addr, input logic [31:0] got, input int k,
                         input int kind, input logic [31:0] exp_data);
    snap_t e;
    bus.core2cache_rd_en   = 1'b1;
    bus.core2cache_rd_addr = addr;
    tick();
    bus.core2cache_rd_en = 1'b0;
    check("rd.busy_during", 32'(busy), 32'd1);
    repeat (k - 1) tick();
    case (kind)
      K_PASS: exp_s.pass_c++;
      K_FAIL: begin
        exp_s.fail_c++;
`ifdef CHECKER_LAST_FAIL_EN
        exp_s.lf_addr = addr;
        exp_s.lf_exp  = exp_data;
        exp_s.lf_got  = got;
`endif
      end
      default: exp_s.unk_c++;
    endcase
    note_latency(k);
    sb.push_back(exp_s);
    bus.cache2core_rd_fin  = 1'b1;
    bus.cache2core_rd_data = got;
    tick();
    bus.cache2core_rd_fin = 1'b0;
    e = sb.pop_front();
    check_snap("rd", e);
  endtask

  initial begin
    bus.core2cache_rd_addr = '0;
    bus.core2cache_wr_addr = '0;
    bus.core2cache_wr_data = '0;
    bus.core2cache_rd_en   = 1'b0;
    bus.core2cache_wr_en   = 1'b0;
    bus.cache2core_rd_fin  = 1'b0;
    bus.cache2core_wr_fin  = 1'b0;
    bus.cache2core_rd_data = '0;
    clear_exp();

    vecs[0] = '{K_WR,   27'h0400004, 32'h0000_0001, 3, 32'h0};
    vecs[1] = '{K_PASS, 27'h0400004, 32'h0000_0001, 5, 32'h0};
    vecs[2] = '{K_FAIL, 27'h0400004, 32'h0000_DEAD, 2, 32'h0000_0001};
    vecs[3] = '{K_UNK,  27'h0000123, 32'h0000_0000, 1, 32'h0};
    vecs[4] = '{K_WR,   27'h0000123, 32'hCAFE_BABE, 1, 32'h0};
    vecs[5] = '{K_PASS, 27'h0000123, 32'hCAFE_BABE, 7, 32'h0};
    vecs[6] = '{K_WR,   27'h0400004, 32'h0000_0055, 2, 32'h0};
    vecs[7] = '{K_PASS, 27'h0400004, 32'h0000_0055, 1, 32'h0};
    vecs[8] = '{K_FAIL, 27'h0400004, 32'h0000_0001, 3, 32'h0000_0055};
    vecs[9] = '{K_UNK,  27'h4400004, 32'h0000_0055, 2, 32'h0};

    // Reset state
    tick();
    tick();
    check_all_zero("reset", 1'b0);
    rst = 1'b0;
    tick();
    check_all_zero("post_reset", 1'b0);

    // Table-driven traffic
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].kind == K_WR)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].k);
      else
        do_read(vecs[i].addr, vecs[i].data, vecs[i].k, vecs[i].kind, vecs[i].exp_data);
    end
    check("vec.proto", 32'(proto_err), 32'd0);

    // Reset in the middle of an outstanding read, fin delivered afterwards
    bus.core2cache_rd_en   = 1'b1;
    bus.core2cache_rd_addr = 27'h0400004;
    tick();
    bus.core2cache_rd_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst", 1'b0);
    tick();
    rst = 1'b0;
    bus.cache2core_rd_fin  = 1'b1;
    bus.cache2core_rd_data = 32'h1;
    tick();
    bus.cache2core_rd_fin = 1'b0;
    tick();
    check_all_zero("rst_mid_read", 1'b1);

    // Round-robin eviction after ENTRIES+1 distinct writes
    reset_dut();
    for (int i = 0; i <= ENTRIES; i++)
      do_write(27'(27'h100 + i), 32'(32'hA0 + i), 1);
    do_read(27'h100, 32'h0, 1, K_UNK, 32'h0);
    do_read(27'(27'h100 + ENTRIES), 32'(32'hA0 + ENTRIES), 1, K_PASS, 32'h0);
    do_read(27'h101, 32'hA1, 2, K_PASS, 32'h0);

    // Simultaneous rd_en/wr_en, then a stray wr_fin while idle
    reset_dut();
    bus.core2cache_rd_en = 1'b1;
    bus.core2cache_wr_en = 1'b1;
    tick();
    bus.core2cache_rd_en = 1'b0;
    bus.core2cache_wr_en = 1'b0;
    check("both_en.busy", 32'(busy), 32'd0);
    check("both_en.proto", 32'(proto_err), 32'd1);
    bus.cache2core_wr_fin = 1'b1;
    tick();
    bus.cache2core_wr_fin = 1'b0;
    tick();
    check_all_zero("stray_fin", 1'b1);

    // An en during WR_WAIT is flagged but the write still completes
    reset_dut();
    bus.core2cache_wr_en   = 1'b1;
    bus.core2cache_wr_addr = 27'h55;
    bus.core2cache_wr_data = 32'h77;
    tick();
    bus.core2cache_wr_en = 1'b0;
    bus.core2cache_rd_en = 1'b1;
    tick();
    bus.core2cache_rd_en = 1'b0;
    check("en_in_wait.proto", 32'(proto_err), 32'd1);
    check("en_in_wait.busy", 32'(busy), 32'd1);
    bus.cache2core_wr_fin = 1'b1;
    tick();
    bus.cache2core_wr_fin = 1'b0;
    check("en_in_wait.busy_after", 32'(busy), 32'd0);
    note_latency(2);
    do_read(27'h55, 32'h77, 1, K_PASS, 32'h0);

    // Timeout on a read that never completes, then a normal read
    reset_dut();
    bus.core2cache_rd_en   = 1'b1;
    bus.core2cache_rd_addr = 27'h7;
    tick();
    bus.core2cache_rd_en = 1'b0;
    repeat (TIMEOUT - 1) tick();
    check("to.busy_before", 32'(busy), 32'd1);
    check("to.flag_before", 32'(timeout_flag), 32'd0);
    tick();
    check("to.busy_after", 32'(busy), 32'd0);
    check("to.flag_after", 32'(timeout_flag), 32'd1);
    check("to.unknown", 32'(unknown_count), 32'd0);
    check("to.max_lat", 32'(max_latency), 32'd0);
    do_read(27'h7, 32'h0, 2, K_UNK, 32'h0);
    check("to.flag_sticky", 32'(timeout_flag), 32'd1);
    check("to.proto", 32'(proto_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
